tdc_frame_tx: RTL and testbench

// - Stage directly upstream of the Uart instance in top.
// - Accepts finished TDC measurements (start->stop interval count plus overflow flag) from the TDC core.
// - Frames each measurement into a byte packet and feeds it to the Uart over the axi_valid/axi_ready/axi_data byte handshake.
// - Holds one extra measurement so the TDC core is not stalled while a frame is on the wire.

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_frame_tx.sv | 155 +++++++++++++++
 tb/tb_tdc_frame_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement framer feeding the Uart.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    STAT,
    DATA,
    CHK
  } tdc_tx_state_t;

  localparam int unsigned FRAME_OVERHEAD    = 3;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/tdc_frame_tx.sv
// Frames TDC measurements as SYNC, STATUS, data bytes (LSB first), CHK and streams
// them to the Uart byte handshake, with one pending slot so the TDC core is not stalled.
module tdc_frame_tx
  import tdc_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              meas_valid,
  output logic              meas_ready,
  input  logic [DATA_W-1:0] meas_data,
  input  logic              meas_ovf,
  output logic              axi_valid,
  input  logic              axi_ready,
  output logic [7:0]        axi_data
);

  localparam int unsigned     NBYTES   = DATA_W / 8;
  localparam int unsigned     IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  tdc_tx_state_t     state, nxt_state;
  logic [IDX_W-1:0]  byte_idx, nxt_idx;
  logic [6:0]        seq, nxt_seq;
  logic [7:0]        frame_status, nxt_status;
  logic [DATA_W-1:0] active_data, nxt_active_data;
  logic              active_ovf, nxt_active_ovf;
  logic [DATA_W-1:0] pend_data, nxt_pend_data;
  logic              pend_ovf, nxt_pend_ovf;
  logic              pend_full, nxt_pend_full;
  logic              meas_hs;
  logic [7:0]        data_bytes [NBYTES];
  logic [7:0]        chk;
  logic [7:0]        nxt_byte;

  assign meas_ready = !pend_full;
  assign meas_hs    = meas_valid && !pend_full;

  always_comb begin
    chk = frame_status;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      data_bytes[i] = active_data[i*8 +: 8];
      chk           = chk ^ data_bytes[i];
    end
  end

  always_comb begin
    nxt_state       = state;
    nxt_idx         = byte_idx;
    nxt_seq         = seq;
    nxt_status      = frame_status;
    nxt_active_data = active_data;
    nxt_active_ovf  = active_ovf;
    nxt_pend_data   = pend_data;
    nxt_pend_ovf    = pend_ovf;
    nxt_pend_full   = pend_full;

    unique case (state)
      IDLE: begin
        if (meas_hs) begin
          nxt_active_data = meas_data;
          nxt_active_ovf  = meas_ovf;
          nxt_state       = SYNC;
        end
      end
      SYNC: begin
        if (axi_ready) begin
          // STATUS and CHK use the pre-increment seq, so latch it here
          nxt_status = {seq, active_ovf};
          nxt_seq    = seq + 7'd1;
          nxt_state  = STAT;
        end
      end
      STAT: begin
        if (axi_ready) begin
          nxt_idx   = '0;
          nxt_state = DATA;
        end
      end
      DATA: begin
        if (axi_ready) begin
          if (byte_idx == LAST_IDX) nxt_state = CHK;
          else                      nxt_idx   = byte_idx + 1'b1;
        end
      end
      CHK: begin
        if (axi_ready) begin
          if (pend_full) begin
            nxt_active_data = pend_data;
            nxt_active_ovf  = pend_ovf;
            nxt_pend_full   = 1'b0;
            nxt_state       = SYNC;
          end else if (meas_hs) begin
            nxt_active_data = meas_data;
            nxt_active_ovf  = meas_ovf;
            nxt_state       = SYNC;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase

    // A word arriving on the CHK-accept edge bypasses pending straight into active
    if (meas_hs && state != IDLE && !(state == CHK && axi_ready)) begin
      nxt_pend_data = meas_data;
      nxt_pend_ovf  = meas_ovf;
      nxt_pend_full = 1'b1;
    end
  end

  always_comb begin
    nxt_byte = '0;
    unique case (nxt_state)
      SYNC:    nxt_byte = SYNC_BYTE;
      STAT:    nxt_byte = nxt_status;
      DATA:    nxt_byte = data_bytes[nxt_idx];
      CHK:     nxt_byte = chk;
      default: nxt_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_idx     <= '0;
      seq          <= '0;
      frame_status <= '0;
      active_data  <= '0;
      active_ovf   <= 1'b0;
      pend_data    <= '0;
      pend_ovf     <= 1'b0;
      pend_full    <= 1'b0;
      axi_valid    <= 1'b0;
      axi_data     <= '0;
    end else begin
      state        <= nxt_state;
      byte_idx     <= nxt_idx;
      seq          <= nxt_seq;
      frame_status <= nxt_status;
      active_data  <= nxt_active_data;
      active_ovf   <= nxt_active_ovf;
      pend_data    <= nxt_pend_data;
      pend_ovf     <= nxt_pend_ovf;
      pend_full    <= nxt_pend_full;
      axi_valid    <= (nxt_state != IDLE);
      // Hold the presented byte while the Uart stalls
      if (!axi_valid || axi_ready) axi_data <= nxt_byte;
    end
  end

endmodule

// File: tb/tb_tdc_frame_tx.sv
// Self-checking bench for tdc_frame_tx: directed scenarios plus a randomized
// 129-frame run, all compared against a byte-stream reference model.
module tb_tdc_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        meas_valid = 1'b0;
  logic        meas_ready;
  logic [23:0] meas_data = '0;
  logic        meas_ovf = 1'b0;
  logic        axi_valid;
  logic        axi_ready;
  logic [7:0]  axi_data;

  logic rnd_mode    = 1'b0;
  logic ready_force = 1'b1;
  logic ready_rnd   = 1'b1;
  assign axi_ready = rnd_mode ? ready_rnd : ready_force;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic [7:0]  got[$];
  int unsigned got_cyc[$];
  logic [7:0]  exp_q[$];
  logic [6:0]  exp_seq = '0;

  tdc_frame_tx #(
    .DATA_W   (24),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .meas_data (meas_data),
    .meas_ovf  (meas_ovf),
    .axi_valid (axi_valid),
    .axi_ready (axi_ready),
    .axi_data  (axi_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && axi_valid && axi_ready) begin
      got.push_back(axi_data);
      got_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) ready_rnd <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference frame: sync, {seq,ovf}, data bytes LSB first, XOR of status and data
  function automatic void model_add(input logic [23:0] d, input logic o);
    logic [7:0] st;
    logic [7:0] x;
    logic [7:0] b;
    st = {exp_seq, o};
    x  = st;
    exp_q.push_back(8'hA5);
    exp_q.push_back(st);
    for (int i = 0; i < 3; i++) begin
      b = 8'((d >> (8 * i)) & 24'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
    exp_seq = exp_seq + 7'd1;
  endfunction

  task automatic clear_q();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    exp_seq = '0;
  endtask

  task automatic do_reset();
    meas_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    clear_q();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic push_meas(input logic [23:0] d, input logic o,
                           output int unsigned waited, output int unsigned got_n);
    meas_valid = 1'b1;
    meas_data  = d;
    meas_ovf   = o;
    waited     = 0;
    while (!meas_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    got_n = got.size();
    chk("meas_accept", 32'(meas_ready), 32'd1);
    model_add(d, o);
    @(negedge clk);
  endtask

  task automatic drain_cmp(input string tag);
    int unsigned t;
    t = 0;
    while ((got.size() < exp_q.size() || axi_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, 32'(t < 5000), 32'd1);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int unsigned w;
    int unsigned gn;
    int unsigned base;
    int unsigned t;
    logic [7:0] lit_a [6];
    logic [7:0] lit_b [6];
    lit_a = '{8'hA5, 8'h00, 8'h56, 8'h34, 8'h12, 8'h70};
    lit_b = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFE};

    // Reset state
    #1;
    chk("rst_axi_valid", 32'(axi_valid), 32'd0);
    chk("rst_axi_data", 32'(axi_data), 32'd0);
    chk("rst_meas_ready", 32'(meas_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single frame with one-cycle latency
    chk("idle_valid", 32'(axi_valid), 32'd0);
    push_meas(24'h123456, 1'b0, w, gn);
    meas_valid = 1'b0;
    chk("latency_valid", 32'(axi_valid), 32'd1);
    chk("latency_sync", 32'(axi_data), 32'hA5);
    drain_cmp("single");
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("single_lit%0d", i), 32'(got[i]), 32'(lit_a[i]));

    // Backpressure on data byte 1
    base = got.size();
    push_meas(24'h123456, 1'b0, w, gn);
    meas_valid = 1'b0;
    t = 0;
    while (got.size() < base + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach", 32'(t < 100), 32'd1);
    ready_force = 1'b0;
    repeat (5) begin
      chk("bp_valid", 32'(axi_valid), 32'd1);
      chk("bp_data", 32'(axi_data), 32'h34);
      @(negedge clk);
    end
    ready_force = 1'b1;
    drain_cmp("bp");

    // Buffering and gapless back-to-back frames
    do_reset();
    push_meas(24'hA1B2C3, 1'b0, w, gn);
    push_meas(24'h0F1E2D, 1'b1, w, gn);
    chk("pend_full_ready", 32'(meas_ready), 32'd0);
    push_meas(24'h778899, 1'b0, w, gn);
    meas_valid = 1'b0;
    chk("w3_after_frame0", gn, 32'd6);
    drain_cmp("b2b");
    if (got.size() >= 18) begin
      chk("b2b_no_gap", got_cyc[17] - got_cyc[0], 32'd17);
      chk("b2b_seq0", 32'(got[1] >> 1), 32'd0);
      chk("b2b_seq1", 32'(got[7] >> 1), 32'd1);
      chk("b2b_seq2", 32'(got[13] >> 1), 32'd2);
    end

    // Overflow flag frame
    do_reset();
    push_meas(24'h0000FF, 1'b1, w, gn);
    meas_valid = 1'b0;
    drain_cmp("ovf");
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("ovf_lit%0d", i), 32'(got[i]), 32'(lit_b[i]));

    // Randomized traffic across the seq wrap
    do_reset();
    rnd_mode = 1'b1;
    for (int i = 0; i < 129; i++) begin
      push_meas(24'($urandom), 1'($urandom_range(0, 1)), w, gn);
      if ($urandom_range(0, 3) == 0) begin
        meas_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    meas_valid = 1'b0;
    drain_cmp("rnd");
    rnd_mode = 1'b0;
    if (got.size() > 769) begin
      chk("seq127", 32'(got[127*6+1] >> 1), 32'd127);
      chk("seq_wrap", 32'(got[128*6+1] >> 1), 32'd0);
    end

    // Reset asserted mid-frame
    do_reset();
    base = got.size();
    push_meas(24'h445566, 1'b0, w, gn);
    meas_valid = 1'b0;
    t = 0;
    while (got.size() < base + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach", 32'(t < 100), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(axi_valid), 32'd0);
    chk("mid_rst_data", 32'(axi_data), 32'd0);
    chk("mid_rst_ready", 32'(meas_ready), 32'd1);
    @(negedge clk);
    clear_q();
    rst = 1'b1;
    @(negedge clk);
    push_meas(24'hABCDEF, 1'b0, w, gn);
    meas_valid = 1'b0;
    drain_cmp("after_rst");
    if (got.size() > 1) chk("after_rst_status", 32'(got[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
